// File: rtl/audio_sample_pacer_if.sv
// Producer-side stereo PCM handshake into the sample pacer.
//   in_valid : producer offers a left/right pair
//   in_ready : pacer FIFO can accept the pair this cycle
//   in_left  : signed 16-bit left sample
//   in_right : signed 16-bit right sample
interface audio_sample_pacer_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_left;
  logic signed [15:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/audio_sample_pacer.sv
// Stereo sample FIFO plus fractional-rate pacer feeding the attenuator stage.
// One pair is released per output-rate tick; on an empty FIFO the last pair
// is held (or zeroed under mute) and an underflow strobe is raised.
//   clk, reset  : system clock, synchronous active-high reset
//   in_if       : valid/ready stereo input (slave side)
//   flush       : single-cycle discard of FIFO contents
//   mute        : released samples read as zero while high
//   out_left/out_right : registered signed outputs to the attenuator
//   sample_tick : pulse in the cycle the outputs take a new value
//   underflow   : pulse on a tick that found the FIFO empty
//   level       : FIFO occupancy, 0..DEPTH
module audio_sample_pacer #(
  parameter int unsigned CLK_HZ    = 30000000,
  parameter int unsigned SAMPLE_HZ = 44100,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  audio_sample_pacer_if.slave      in_if,
  input  logic                     flush,
  input  logic                     mute,
  output logic signed [15:0]       out_left,
  output logic signed [15:0]       out_right,
  output logic                     sample_tick,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(CLK_HZ) + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [AW-1:0]      acc_q, acc_d, acc_n;
  logic               wrap_c;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic signed [15:0] out_left_q, out_left_d;
  logic signed [15:0] out_right_q, out_right_d;
  logic               tick_q, tick_d;
  logic               underflow_q, underflow_d;
  logic               in_ready_c, push_c, pop_c;
  logic [31:0]        head_c;
  logic [31:0]        mem_q [DEPTH];

  // Fractional clock enable: acc stays below CLK_HZ, so acc + SAMPLE_HZ fits in AW bits.
  always_comb begin
    acc_n  = acc_q + AW'(SAMPLE_HZ);
    wrap_c = (acc_n >= AW'(CLK_HZ));
    acc_d  = wrap_c ? (acc_n - AW'(CLK_HZ)) : acc_n;
  end

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign in_ready_c     = (level_q != LW'(DEPTH)) && !flush;
  assign in_if.in_ready = in_ready_c;
  assign push_c         = in_if.in_valid && in_ready_c;
  // A flush cycle looks empty to the pacer; a same-cycle push on empty is not poppable.
  assign pop_c          = wrap_c && (level_q != '0) && !flush;
  assign head_c         = mem_q[rd_ptr_q];

  // Pointer, occupancy and output-stage next state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    tick_d      = wrap_c;
    underflow_d = wrap_c && !pop_c;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    if (pop_c) begin
      out_left_d  = mute ? 16'sd0 : head_c[31:16];
      out_right_d = mute ? 16'sd0 : head_c[15:0];
    end else if (wrap_c && mute) begin
      out_left_d  = 16'sd0;
      out_right_d = 16'sd0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      tick_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      tick_q      <= tick_d;
      underflow_q <= underflow_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {in_if.in_left, in_if.in_right};
  end

  assign out_left    = out_left_q;
  assign out_right   = out_right_q;
  assign sample_tick = tick_q;
  assign underflow   = underflow_q;
  assign level       = level_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Bench for audio_sample_pacer: queue-based reference model plus directed and
// randomized steps; a second instance exercises a fractional 7:3 rate.
module tb_audio_sample_pacer;
  localparam int unsigned C_HZ  = 100;
  localparam int unsigned S_HZ  = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic mute = 1'b0;
  logic b_flush = 1'b0;
  logic b_mute = 1'b0;
  always #5 clk = ~clk;

  audio_sample_pacer_if a_if ();
  audio_sample_pacer_if b_if ();

  logic signed [15:0] a_l, a_r, b_l, b_r;
  logic               a_tick, a_uf, b_tick, b_uf;
  logic [LW-1:0]      a_level, b_level;

  audio_sample_pacer #(.CLK_HZ(C_HZ), .SAMPLE_HZ(S_HZ), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(reset), .in_if(a_if), .flush(flush), .mute(mute),
    .out_left(a_l), .out_right(a_r), .sample_tick(a_tick), .underflow(a_uf),
    .level(a_level));

  audio_sample_pacer #(.CLK_HZ(7), .SAMPLE_HZ(3), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(reset), .in_if(b_if), .flush(b_flush), .mute(b_mute),
    .out_left(b_l), .out_right(b_r), .sample_tick(b_tick), .underflow(b_uf),
    .level(b_level));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a wrap happens in the k-th cycle out of reset exactly when
  // floor(k*S/C) steps; the FIFO is a plain queue of {left,right}.
  logic [31:0]        mq [$];
  longint             m_k = 0;
  logic signed [15:0] m_l = '0;
  logic signed [15:0] m_r = '0;
  bit                 m_tick = 1'b0;
  bit                 m_uf = 1'b0;

  function automatic bit is_wrap(longint k);
    return ((k * longint'(S_HZ)) / longint'(C_HZ)) != (((k - 1) * longint'(S_HZ)) / longint'(C_HZ));
  endfunction

  always @(posedge clk) begin
    bit          wr, rdy, do_pop;
    logic [31:0] h;
    if (reset) begin
      mq.delete();
      m_k = 0; m_l = '0; m_r = '0; m_tick = 1'b0; m_uf = 1'b0;
    end else begin
      m_k++;
      wr     = is_wrap(m_k);
      rdy    = (mq.size() != int'(DEPTH)) && !flush;
      do_pop = wr && !flush && (mq.size() != 0);
      m_tick = wr;
      m_uf   = wr && !do_pop;
      if (do_pop) begin
        h = mq.pop_front();
        m_l = mute ? 16'sd0 : h[31:16];
        m_r = mute ? 16'sd0 : h[15:0];
      end else if (wr && mute) begin
        m_l = 16'sd0; m_r = 16'sd0;
      end
      if (flush) mq.delete();
      if (a_if.in_valid && rdy) mq.push_back({a_if.in_left, a_if.in_right});
    end
  end

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(string ctx);
    chk({ctx, ".out_left"},  a_l, m_l);
    chk({ctx, ".out_right"}, a_r, m_r);
    chk({ctx, ".tick"},      16'(a_tick), 16'(m_tick));
    chk({ctx, ".underflow"}, 16'(a_uf), 16'(m_uf));
    chk({ctx, ".level"},     16'(a_level), 16'(mq.size()));
    chk({ctx, ".in_ready"},  16'(a_if.in_ready), 16'((mq.size() != int'(DEPTH)) && !flush));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_all("model");
  endtask

  task automatic to_tick(output int n);
    n = 0;
    do begin cyc(); n++; end while (!a_tick && n < 40);
    if (!a_tick) chk("tick_timeout", 16'(a_tick), 16'd1);
  endtask

  task automatic wait_pre_wrap();
    int guard = 0;
    while (!is_wrap(m_k + 1) && guard < 200) begin cyc(); guard++; end
  endtask

  task automatic restart();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  int          n, bticks, buf_cnt, last, bad_sp, aticks, consec;
  bit          prev_tick;
  logic [15:0] t2_l [4];
  logic [15:0] t2_r [4];
  logic [15:0] p5_l [4];
  logic [15:0] p5_r [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.in_valid = 1'b0; a_if.in_left = '0; a_if.in_right = '0;
    b_if.in_valid = 1'b0; b_if.in_left = '0; b_if.in_right = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset.level", 16'(a_level), 16'd0);
    chk("reset.in_ready", 16'(a_if.in_ready), 16'd1);
    reset = 1'b0;

    // Fractional rate 3/7 on dut_b, 1/10 on dut_a, over 700 cycles.
    bticks = 0; buf_cnt = 0; last = -1; bad_sp = 0; aticks = 0;
    for (int i = 1; i <= 700; i++) begin
      cyc();
      if (a_tick) aticks++;
      if (b_uf) buf_cnt++;
      if (b_tick) begin
        if (last >= 0 && !((i - last) == 2 || (i - last) == 3)) bad_sp++;
        last = i;
        bticks++;
      end
    end
    chk("frac.ticks", 16'(bticks), 16'd300);
    chk("frac.spacing_bad", 16'(bad_sp), 16'd0);
    chk("frac.underflows", 16'(buf_cnt), 16'd300);
    chk("frac.b_level", 16'(b_level), 16'd0);
    chk("frac.b_left", b_l, 16'd0);
    chk("frac.b_right", b_r, 16'd0);
    chk("frac.a_ticks", 16'(aticks), 16'd70);

    // Even pacing with three pairs, then held output and underflow.
    restart();
    a_if.in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_if.in_left = 16'(i); a_if.in_right = 16'(-i);
      cyc();
    end
    a_if.in_valid = 1'b0;
    to_tick(n);
    chk("even.first_gap", 16'(n), 16'd7);
    chk("even.p1.l", a_l, 16'd1);
    chk("even.p1.r", a_r, 16'hffff);
    chk("even.p1.uf", 16'(a_uf), 16'd0);
    to_tick(n);
    chk("even.gap2", 16'(n), 16'd10);
    chk("even.p2.l", a_l, 16'd2);
    chk("even.p2.r", a_r, 16'hfffe);
    to_tick(n);
    chk("even.gap3", 16'(n), 16'd10);
    chk("even.p3.l", a_l, 16'd3);
    chk("even.p3.r", a_r, 16'hfffd);
    chk("even.p3.level", 16'(a_level), 16'd0);
    for (int i = 0; i < 2; i++) begin
      to_tick(n);
      chk("even.hold.gap", 16'(n), 16'd10);
      chk("even.hold.uf", 16'(a_uf), 16'd1);
      chk("even.hold.l", a_l, 16'd3);
      chk("even.hold.r", a_r, 16'hfffd);
    end

    // Full FIFO: fill before the first tick, 5th pair waits for a pop.
    restart();
    a_if.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t2_l[i] = 16'($urandom); t2_r[i] = 16'($urandom);
      a_if.in_left = t2_l[i]; a_if.in_right = t2_r[i];
      cyc();
    end
    chk("full.level", 16'(a_level), 16'd4);
    chk("full.in_ready", 16'(a_if.in_ready), 16'd0);
    a_if.in_left = 16'h1234; a_if.in_right = 16'h4321;
    repeat (5) begin
      cyc();
      chk("full.blocked", 16'(a_if.in_ready), 16'd0);
    end
    cyc();
    chk("full.pop.tick", 16'(a_tick), 16'd1);
    chk("full.pop.level", 16'(a_level), 16'd3);
    chk("full.pop.ready", 16'(a_if.in_ready), 16'd1);
    cyc();
    chk("full.refill.level", 16'(a_level), 16'd4);
    chk("full.refill.ready", 16'(a_if.in_ready), 16'd0);
    a_if.in_valid = 1'b0;

    // Flush coinciding with a wrap at level 3.
    to_tick(n);
    wait_pre_wrap();
    chk("flush.pre_level", 16'(a_level), 16'd3);
    flush = 1'b1;
    a_if.in_valid = 1'b1; a_if.in_left = 16'h5555; a_if.in_right = 16'haaaa;
    cyc();
    chk("flush.uf", 16'(a_uf), 16'd1);
    chk("flush.hold.l", a_l, t2_l[1]);
    chk("flush.hold.r", a_r, t2_r[1]);
    chk("flush.level", 16'(a_level), 16'd0);
    flush = 1'b0;
    a_if.in_valid = 1'b0;
    cyc();
    chk("flush.dropped", 16'(a_level), 16'd0);

    // Mute over the 2nd and 3rd ticks of four queued pairs.
    a_if.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p5_l[i] = 16'($urandom); p5_r[i] = 16'($urandom);
      a_if.in_left = p5_l[i]; a_if.in_right = p5_r[i];
      cyc();
    end
    a_if.in_valid = 1'b0;
    to_tick(n);
    chk("mute.p1.l", a_l, p5_l[0]);
    chk("mute.p1.r", a_r, p5_r[0]);
    chk("mute.p1.level", 16'(a_level), 16'd3);
    for (int i = 0; i < 2; i++) begin
      wait_pre_wrap();
      mute = 1'b1;
      cyc();
      chk("mute.zero.l", a_l, 16'd0);
      chk("mute.zero.r", a_r, 16'd0);
      chk("mute.level", 16'(a_level), 16'(2 - i));
    end
    mute = 1'b0;
    wait_pre_wrap();
    cyc();
    chk("mute.p4.l", a_l, p5_l[3]);
    chk("mute.p4.r", a_r, p5_r[3]);
    chk("mute.p4.level", 16'(a_level), 16'd0);

    // Reset mid-stream with level 2 and outputs at full-scale extremes.
    a_if.in_valid = 1'b1;
    a_if.in_left = 16'h7fff; a_if.in_right = 16'h8000;
    cyc();
    a_if.in_left = 16'h0101; a_if.in_right = 16'h0202;
    cyc();
    cyc();
    a_if.in_valid = 1'b0;
    to_tick(n);
    chk("rst.pre.l", a_l, 16'h7fff);
    chk("rst.pre.r", a_r, 16'h8000);
    chk("rst.pre.level", 16'(a_level), 16'd2);
    restart();
    chk("rst.l", a_l, 16'd0);
    chk("rst.r", a_r, 16'd0);
    chk("rst.level", 16'(a_level), 16'd0);
    chk("rst.ready", 16'(a_if.in_ready), 16'd1);
    to_tick(n);
    chk("rst.first_tick", 16'(n), 16'(C_HZ / S_HZ));

    // Randomized traffic: heavy then light producer, random mute and flush.
    prev_tick = 1'b0;
    consec = 0;
    for (int i = 0; i < 800; i++) begin
      a_if.in_valid = (i < 400) ? ($urandom_range(1, 0) == 1) : ($urandom_range(15, 0) == 0);
      a_if.in_left  = 16'($urandom);
      a_if.in_right = 16'($urandom);
      mute  = ($urandom_range(7, 0) == 0);
      flush = ($urandom_range(59, 0) == 0);
      cyc();
      if (prev_tick && a_tick) consec++;
      prev_tick = a_tick;
    end
    chk("rand.consecutive_ticks", 16'(consec), 16'd0);
    a_if.in_valid = 1'b0; mute = 1'b0; flush = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
